extensor_imediato_pipe: RTL and testbench
=========================================

Name: extensor_imediato_pipe

Overview:
- Parametrised, pipelined successor to the processor's immediate extender.
- Accepts a constant plus control code through a valid/ready handshake and forms the full-width immediate.
- Modes: sign-extend, zero-extend, low-byte merge (lcl), high-byte merge (lch) and shifted immediate.
- Results, tagged with their destination register, are buffered in a small output FIFO between decode and register-file writeback.

Parameters:
- LARGURA_PALAVRA, 16, output word width W; must satisfy W >= 2*LARGURA_BYTE.
- LARGURA_CONST, 11, input constant width C; must satisfy LARGURA_BYTE <= C <= W.
- LARGURA_BYTE, 8, byte width B used by the lcl, lch and shift modes.
- LARGURA_TAG, 4, width of the destination tag carried with each result.
- PROFUNDIDADE, 2, output FIFO depth; power of two, >= 2.

Ports:
- clock  in  1  single rising-edge clock.
- reset_n  in  1  synchronous reset, active low.
- entrada_valida  in  1  input request valid.
- entrada_pronta  out  1  block can accept a request.
- controle  in  3  mode code.
- constante  in  C  signed constant field.
- valor_atual  in  W  current destination-register value, used by merge modes.
- destino_in  in  LARGURA_TAG  destination tag.
- saida_valida  out  1  result at FIFO head is valid.
- saida_pronta  in  1  consumer accepts the head.
- palavraSaida  out  W  result word at FIFO head.
- destino_out  out  LARGURA_TAG  tag of the head entry.

Behaviour:
- Clock and reset: one clock; reset_n is synchronous, active low, sampled on the rising edge of clock.
- Reset state: FIFO cleared (count=0, pointers=0); saida_valida=0; palavraSaida=0; destino_out=0; entrada_pronta=1 in the first cycle after reset.
- Reset mid-operation: all in-flight and buffered entries are discarded.
- Input acceptance: a request is accepted in a cycle where entrada_valida && entrada_pronta. controle, constante, valor_atual and destino_in are sampled only in that cycle.
- entrada_pronta = (count < PROFUNDIDADE). It is combinational from state only, with no dependence on saida_pronta. When the FIFO is full, no request is accepted, even if a pop happens in the same cycle.
- Result formation (combinational on the accepted inputs, written into the FIFO at the acceptance edge):
  - 000 sign-extend: constante[C-1] replicated into bits [W-1:C].
  - 001 zero-extend: zeros in bits [W-1:C].
  - 010 lcl: valor_atual with bits [B-1:0] replaced by constante[B-1:0].
  - 011 lch: valor_atual with bits [2B-1:B] replaced by constante[B-1:0].
  - 100 shifted immediate: (sign-extended constante) << B, truncated to W bits.
  - 101, 110, 111: result 0.
- Latency: 1 cycle. A request accepted at edge N is visible on saida_valida, palavraSaida and destino_out after edge N when the FIFO was empty. Outputs are driven from FIFO storage, never combinationally from the inputs.
- Output handshake: the head is popped at an edge where saida_valida && saida_pronta. palavraSaida and destino_out stay stable while saida_valida=1 and saida_pronta=0.
- Simultaneous push and pop with 0 < count < PROFUNDIDADE: count unchanged, both pointers advance.
- Push and pop with count=0 cannot occur: the pop requires saida_valida. The push alone lands, and the result appears next cycle.
- Ordering: strict FIFO order. Pointers wrap modulo PROFUNDIDADE.
- Illegal-code behaviour (codes 101–111): the result is 0 and no flag is raised in the default build.

Optional Feature:
- Macro: EXTENSOR_ERRO_EN.
- Defined:
  - Adds output port erro_out (1 bit), carried in the FIFO alongside each entry.
  - erro_out=1 for entries produced by codes 101–111, otherwise 0; the entry's word is still 0.
  - erro_out resets to 0.
- Undefined: no erro_out port and no extra FIFO storage; illegal codes silently yield 0.

Test Plan:
- Reset then single sign-extend: controle=000, constante=11'h400, destino_in=3; saida_pronta=1 → one cycle later saida_valida=1, palavraSaida=16'hFC00, destino_out=3; next cycle saida_valida=0.
- Mode sweep, constante=11'h0A5, valor_atual=16'h1234:
  - 001 → 16'h00A5
  - 010 → 16'h12A5
  - 011 → 16'hA534
  - 100 → 16'hA500
  - 111 → 16'h0000 (erro_out=1 when EXTENSOR_ERRO_EN is defined)
- Backpressure: saida_pronta=0, three back-to-back valid requests (tags 1,2,3) → first two accepted, entrada_pronta=0 while full, request 3 held. Raise saida_pronta → outputs tag 1, then tag 2, then tag 3, with no loss or duplication.
- Simultaneous push/pop: with count=1, push and pop in the same cycle → count stays 1 and the new result appears next, in order.
- Reset mid-operation: FIFO holding 2 entries, reset_n=0 for one edge → saida_valida=0, palavraSaida=0, entrada_pronta=1; previous entries never appear.
- Parameter variant: LARGURA_PALAVRA=32, LARGURA_CONST=16, constante=16'h8001, controle=000 → 32'hFFFF8001; controle=100 → 32'hFF800100.

Source files
------------

// File: rtl/extensor_imediato_pipe.sv
// Pipelined immediate extender: forms a W-bit immediate from a C-bit constant and buffers
// tagged results in a small FIFO. Define EXTENSOR_ERRO_EN to add the erro_out flag per entry.
module extensor_imediato_pipe #(
  parameter int unsigned LARGURA_PALAVRA = 16,
  parameter int unsigned LARGURA_CONST   = 11,
  parameter int unsigned LARGURA_BYTE    = 8,
  parameter int unsigned LARGURA_TAG     = 4,
  parameter int unsigned PROFUNDIDADE    = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       entrada_valida,
  output logic                       entrada_pronta,
  input  logic [2:0]                 controle,
  input  logic [LARGURA_CONST-1:0]   constante,
  input  logic [LARGURA_PALAVRA-1:0] valor_atual,
  input  logic [LARGURA_TAG-1:0]     destino_in,
  output logic                       saida_valida,
  input  logic                       saida_pronta,
  output logic [LARGURA_PALAVRA-1:0] palavraSaida,
`ifdef EXTENSOR_ERRO_EN
  output logic                       erro_out,
`endif
  output logic [LARGURA_TAG-1:0]     destino_out
);

  localparam int unsigned W     = LARGURA_PALAVRA;
  localparam int unsigned B     = LARGURA_BYTE;
  localparam int unsigned PtrW  = $clog2(PROFUNDIDADE);
  localparam int unsigned CntW  = PtrW + 1;

  logic [W-1:0]           word_mem [PROFUNDIDADE];
  logic [LARGURA_TAG-1:0] tag_mem  [PROFUNDIDADE];
`ifdef EXTENSOR_ERRO_EN
  logic                   err_mem  [PROFUNDIDADE];
  logic                   erro;
`endif

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  logic [W-1:0] resultado;
  logic [W-1:0] sext;
  logic [W-1:0] byte_lo;
  logic [W-1:0] mask_lo;

  // Result formation
  always_comb begin
    sext      = W'($signed(constante));
    byte_lo   = W'(constante[B-1:0]);
    mask_lo   = W'({B{1'b1}});
    resultado = '0;
`ifdef EXTENSOR_ERRO_EN
    erro      = 1'b0;
`endif
    case (controle)
      3'b000:  resultado = sext;
      3'b001:  resultado = W'(constante);
      3'b010:  resultado = (valor_atual & ~mask_lo) | byte_lo;
      3'b011:  resultado = (valor_atual & ~(mask_lo << B)) | (byte_lo << B);
      3'b100:  resultado = sext << B;
      default: begin
        resultado = '0;
`ifdef EXTENSOR_ERRO_EN
        erro      = 1'b1;
`endif
      end
    endcase
  end

  // Full FIFO refuses pushes even when a pop happens in the same cycle.
  assign entrada_pronta = (count_q < CntW'(PROFUNDIDADE));
  assign saida_valida   = (count_q != '0);
  assign push           = entrada_valida && entrada_pronta;
  assign pop            = saida_valida && saida_pronta;

  assign palavraSaida = word_mem[rd_ptr_q];
  assign destino_out  = tag_mem[rd_ptr_q];
`ifdef EXTENSOR_ERRO_EN
  assign erro_out     = err_mem[rd_ptr_q];
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(PROFUNDIDADE); i++) begin
        word_mem[i] <= '0;
        tag_mem[i]  <= '0;
`ifdef EXTENSOR_ERRO_EN
        err_mem[i]  <= 1'b0;
`endif
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        word_mem[wr_ptr_q] <= resultado;
        tag_mem[wr_ptr_q]  <= destino_in;
`ifdef EXTENSOR_ERRO_EN
        err_mem[wr_ptr_q]  <= erro;
`endif
      end
    end
  end

endmodule

// File: tb/tb_extensor_imediato_pipe.sv
// Directed bench for extensor_imediato_pipe: mode table, backpressure, push/pop overlap,
// mid-operation reset and a 32-bit parameter variant.
module tb_extensor_imediato_pipe;

  logic        clock;
  logic        reset_n;
  logic        entrada_valida;
  logic        entrada_pronta;
  logic [2:0]  controle;
  logic [10:0] constante;
  logic [15:0] valor_atual;
  logic [3:0]  destino_in;
  logic        saida_valida;
  logic        saida_pronta;
  logic [15:0] palavraSaida;
  logic [3:0]  destino_out;
`ifdef EXTENSOR_ERRO_EN
  logic        erro_out;
`endif

  logic        v_valida, v_pronta, v_svalida, v_spronta;
  logic [2:0]  v_controle;
  logic [15:0] v_constante;
  logic [31:0] v_valor, v_palavra;
  logic [3:0]  v_din, v_dout;
`ifdef EXTENSOR_ERRO_EN
  logic        v_erro;
`endif

  int total = 0;
  int bad   = 0;

  extensor_imediato_pipe dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .controle       (controle),
    .constante      (constante),
    .valor_atual    (valor_atual),
    .destino_in     (destino_in),
    .saida_valida   (saida_valida),
    .saida_pronta   (saida_pronta),
    .palavraSaida   (palavraSaida),
`ifdef EXTENSOR_ERRO_EN
    .erro_out       (erro_out),
`endif
    .destino_out    (destino_out)
  );

  extensor_imediato_pipe #(
    .LARGURA_PALAVRA (32),
    .LARGURA_CONST   (16)
  ) dut32 (
    .clock          (clock),
    .reset_n        (reset_n),
    .entrada_valida (v_valida),
    .entrada_pronta (v_pronta),
    .controle       (v_controle),
    .constante      (v_constante),
    .valor_atual    (v_valor),
    .destino_in     (v_din),
    .saida_valida   (v_svalida),
    .saida_pronta   (v_spronta),
    .palavraSaida   (v_palavra),
`ifdef EXTENSOR_ERRO_EN
    .erro_out       (v_erro),
`endif
    .destino_out    (v_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  ctl;
    logic [10:0] c;
    logic [15:0] v;
    logic [3:0]  tag;
    logic [15:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'b000, 11'h400, 16'h0000, 4'd3,  16'hFC00, 1'b0};
    vecs[1]  = '{3'b000, 11'h0A5, 16'h1234, 4'd4,  16'h00A5, 1'b0};
    vecs[2]  = '{3'b001, 11'h0A5, 16'h1234, 4'd5,  16'h00A5, 1'b0};
    vecs[3]  = '{3'b010, 11'h0A5, 16'h1234, 4'd6,  16'h12A5, 1'b0};
    vecs[4]  = '{3'b011, 11'h0A5, 16'h1234, 4'd7,  16'hA534, 1'b0};
    vecs[5]  = '{3'b100, 11'h0A5, 16'h1234, 4'd8,  16'hA500, 1'b0};
    vecs[6]  = '{3'b111, 11'h0A5, 16'h1234, 4'd9,  16'h0000, 1'b1};
    vecs[7]  = '{3'b101, 11'h7FF, 16'hFFFF, 4'd10, 16'h0000, 1'b1};
    vecs[8]  = '{3'b001, 11'h7FF, 16'hFFFF, 4'd11, 16'h07FF, 1'b0};
    vecs[9]  = '{3'b010, 11'h4FF, 16'hABCD, 4'd12, 16'hABFF, 1'b0};
    vecs[10] = '{3'b100, 11'h400, 16'h0000, 4'd13, 16'h0000, 1'b0};

    reset_n = 1'b0; entrada_valida = 1'b0; saida_pronta = 1'b1;
    controle = '0; constante = '0; valor_atual = '0; destino_in = '0;
    v_valida = 1'b0; v_spronta = 1'b1; v_controle = '0; v_constante = '0;
    v_valor = '0; v_din = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    check("reset_valida", 32'(saida_valida), 32'd0);
    check("reset_palavra", 32'(palavraSaida), 32'd0);
    check("reset_destino", 32'(destino_out), 32'd0);
    check("reset_pronta", 32'(entrada_pronta), 32'd1);
`ifdef EXTENSOR_ERRO_EN
    check("reset_erro", 32'(erro_out), 32'd0);
`endif

    // Table: each vector pushed alone, checked one cycle later, popped the next edge
    for (int i = 0; i < 11; i++) begin
      entrada_valida = 1'b1;
      controle = vecs[i].ctl; constante = vecs[i].c;
      valor_atual = vecs[i].v; destino_in = vecs[i].tag;
      @(posedge clock);
      @(negedge clock);
      entrada_valida = 1'b0;
      controle = 3'b001; constante = 11'h3C3; valor_atual = 16'hDEAD; destino_in = 4'hF;
      check($sformatf("vec%0d_valida", i), 32'(saida_valida), 32'd1);
      check($sformatf("vec%0d_palavra", i), 32'(palavraSaida), 32'(vecs[i].exp));
      check($sformatf("vec%0d_destino", i), 32'(destino_out), 32'(vecs[i].tag));
`ifdef EXTENSOR_ERRO_EN
      check($sformatf("vec%0d_erro", i), 32'(erro_out), 32'(vecs[i].err));
`endif
      @(negedge clock);
      check($sformatf("vec%0d_drained", i), 32'(saida_valida), 32'd0);
    end

    // Backpressure: fill, hold third request, then drain with overlapping push/pop
    saida_pronta = 1'b0;
    entrada_valida = 1'b1; controle = 3'b001;
    constante = 11'h011; destino_in = 4'd1;
    @(negedge clock);
    constante = 11'h022; destino_in = 4'd2;
    @(negedge clock);
    constante = 11'h033; destino_in = 4'd3;
    check("full_pronta", 32'(entrada_pronta), 32'd0);
    check("full_head_tag", 32'(destino_out), 32'd1);
    @(negedge clock);
    check("held_pronta", 32'(entrada_pronta), 32'd0);
    check("held_head_tag", 32'(destino_out), 32'd1);
    check("held_head_word", 32'(palavraSaida), 32'h0011);
    saida_pronta = 1'b1;
    @(negedge clock);
    check("pop1_tag", 32'(destino_out), 32'd2);
    check("pop1_word", 32'(palavraSaida), 32'h0022);
    check("pop1_pronta", 32'(entrada_pronta), 32'd1);
    @(negedge clock);
    entrada_valida = 1'b0;
    check("overlap_valida", 32'(saida_valida), 32'd1);
    check("overlap_tag", 32'(destino_out), 32'd3);
    check("overlap_word", 32'(palavraSaida), 32'h0033);
    check("overlap_pronta", 32'(entrada_pronta), 32'd1);
    @(negedge clock);
    check("bp_empty", 32'(saida_valida), 32'd0);

    // Explicit overlap at count=1 in mode 000
    entrada_valida = 1'b1; controle = 3'b000; constante = 11'h401; destino_in = 4'd5;
    saida_pronta = 1'b0;
    @(negedge clock);
    constante = 11'h002; destino_in = 4'd6; saida_pronta = 1'b1;
    @(negedge clock);
    entrada_valida = 1'b0;
    check("pp_tag", 32'(destino_out), 32'd6);
    check("pp_word", 32'(palavraSaida), 32'h0002);
    check("pp_pronta", 32'(entrada_pronta), 32'd1);
    @(negedge clock);
    check("pp_empty", 32'(saida_valida), 32'd0);

    // Reset with two buffered entries
    saida_pronta = 1'b0; entrada_valida = 1'b1; controle = 3'b001;
    constante = 11'h0AA; destino_in = 4'd7;
    @(negedge clock);
    constante = 11'h0BB; destino_in = 4'd8;
    @(negedge clock);
    entrada_valida = 1'b0;
    check("pre_rst_full", 32'(entrada_pronta), 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_valida", 32'(saida_valida), 32'd0);
    check("rst_palavra", 32'(palavraSaida), 32'd0);
    check("rst_pronta", 32'(entrada_pronta), 32'd1);
    saida_pronta = 1'b1; entrada_valida = 1'b1; constante = 11'h055; destino_in = 4'd9;
    @(negedge clock);
    entrada_valida = 1'b0;
    check("post_rst_tag", 32'(destino_out), 32'd9);
    check("post_rst_word", 32'(palavraSaida), 32'h0055);
    @(negedge clock);
    check("post_rst_empty", 32'(saida_valida), 32'd0);

    // 32-bit variant
    v_valida = 1'b1; v_controle = 3'b000; v_constante = 16'h8001; v_din = 4'd2;
    @(negedge clock);
    v_controle = 3'b100; v_din = 4'd3;
    check("w32_sext", v_palavra, 32'hFFFF8001);
    check("w32_sext_tag", 32'(v_dout), 32'd2);
    @(negedge clock);
    v_controle = 3'b001; v_din = 4'd4;
    check("w32_shift", v_palavra, 32'hFF800100);
    @(negedge clock);
    v_valida = 1'b0;
    check("w32_zext", v_palavra, 32'h00008001);
    check("w32_zext_tag", 32'(v_dout), 32'd4);
    @(negedge clock);
    check("w32_empty", 32'(v_svalida), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
